// File: rtl/lmul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : lmul_arbiter_if
//  Purpose  : Request, response and engine-side signal bundle for the
//             shared FP16 logarithmic multiplier arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface lmul_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    // Requester side
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [N-1:0]    req_ready;

    // Response side
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [15:0]     rsp_data;
    logic            rsp_err;
    logic            rsp_ready;

    // Multiplier engine side
    logic            mul_start;
    logic [15:0]     mul_a;
    logic [15:0]     mul_b;
    logic            mul_done;
    logic [15:0]     mul_result;

    // Status
    logic            busy;

    // Arbiter view
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               mul_start, mul_a, mul_b, busy
    );

    // Environment view (requesters, response consumer, engine)
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               mul_start, mul_a, mul_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/lmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lmul_arbiter
//  Purpose  : Round-robin sharing of one multi-cycle FP16 log multiplier
//             between N requesters, with zero-operand bypass and a timeout
//             watchdog on the engine start/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module lmul_arbiter #(
    parameter int N           = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT     = 16,
    parameter int BYPASS_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    lmul_arbiter_if.slave      bus
);

    localparam int             TW          = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  c_timer_max = TW'(TIMEOUT - 1);
    localparam logic [IDW:0]   c_n         = (IDW + 1)'(N);
    localparam logic [IDW-1:0] c_last_id   = IDW'(N - 1);
    localparam logic [15:0]    c_nan       = 16'h7E00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [TW-1:0]  r_timer;
    logic [15:0]    r_mul_a;
    logic [15:0]    r_mul_b;
    logic [15:0]    r_rsp_data;
    logic           r_rsp_err;

    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [IDW:0]   w_off;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_win;
    logic [15:0]    w_a;
    logic [15:0]    w_b;
    logic           w_zero;
    logic           w_accept;
    logic           w_timeout;
    logic           w_mul_start;
    logic           w_rsp_valid;
    logic           w_busy;

    // Rotate the request vector so the search always begins at bit 0 (= rr_ptr)
    assign w_rot = N'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

    // Lowest set bit of the rotated vector is the distance to the winner
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = (IDW + 1)'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_rr_ptr} + w_off;
    assign w_win     = (w_sum >= c_n) ? IDW'(w_sum - c_n) : IDW'(w_sum);
    assign w_a       = 16'(bus.req_a >> {w_win, 4'b0000});
    assign w_b       = 16'(bus.req_b >> {w_win, 4'b0000});
    assign w_zero    = (BYPASS_ZERO != 0) &&
                       ((w_a[14:0] == 15'd0) || (w_b[14:0] == 15'd0));
    assign w_accept  = (r_state == S_IDLE) && w_found;
    assign w_timeout = (r_timer == c_timer_max);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next      = r_state;
        w_mul_start = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_found) begin
                    w_next = w_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mul_start = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final timer cycle still wins
                if (bus.mul_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/response capture, watchdog timer and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_timer    <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_mul_a <= w_a;
                        r_mul_b <= w_b;
                        r_id    <= w_win;
                        if (w_zero) begin
                            r_rsp_data <= {w_a[15] ^ w_b[15], 15'd0};
                            r_rsp_err  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (bus.mul_done) begin
                        r_rsp_data <= bus.mul_result;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= c_nan;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rr_ptr <= (r_id == c_last_id) ? '0 : r_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_accept ? (N'(1) << w_win) : '0;
    assign bus.mul_start = w_mul_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_lmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lmul_arbiter
//  Purpose  : Self-checking bench for lmul_arbiter: directed vector table,
//             hand-written multi-cycle sequences and a randomized run against
//             a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lmul_arbiter;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lmul_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    lmul_arbiter #(
        .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .BYPASS_ZERO(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: product approximated by log-domain addition
    function automatic logic [15:0] eng_f(input logic [15:0] a, input logic [15:0] b);
        return a + b - 16'h3C00;
    endfunction

    int eng_lat  = 3;   // 0 = engine never answers
    int inj_req  = 0;
    int inj_done = 0;
    int eng_cnt  = 0;
    int starts   = 0;

    // Engine: latches on mul_start, answers after eng_lat cycles; can inject stray pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_cnt         = 0;
            inj_done        = inj_req;
            bus.mul_done    = 1'b0;
            bus.mul_result  = '0;
        end else begin
            bus.mul_done = 1'b0;
            if (inj_done != inj_req) begin
                inj_done       = inj_req;
                bus.mul_done   = 1'b1;
                bus.mul_result = 16'h1111;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.mul_done   = 1'b1;
                    bus.mul_result = eng_f(bus.mul_a, bus.mul_b);
                end
            end
            if (bus.mul_start) begin
                starts++;
                if (eng_lat > 0) eng_cnt = eng_lat;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference arbitration: requester with the smallest forward distance from ptr
    function automatic int model_winner(input logic [N-1:0] v, input int p);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i] && (((i - p + N) % N) < bd)) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 5) == 0) v[14:0] = '0;
        return v;
    endfunction

    task automatic wait_rsp(input int limit);
        int k = 0;
        while (!bus.rsp_valid && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
    endtask

    // One complete transaction with rsp_ready held high
    task automatic run_txn(input logic [N-1:0] valid, input logic [15:0] a,
                           input logic [15:0] b, input logic [N-1:0] exp_ready,
                           input logic [15:0] exp_data, input logic exp_err,
                           input int exp_lat, input string tag);
        int t0, s0, k;
        @(negedge clk);
        bus.req_valid = valid;
        bus.req_a     = {N{a}};
        bus.req_b     = {N{b}};
        bus.rsp_ready = 1'b1;
        #1;
        k = 0;
        while (bus.req_ready == '0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, " grant"}, 64'(bus.req_ready), 64'(exp_ready));
        t0 = cyc;
        s0 = starts;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        wait_rsp(TIMEOUT + 10);
        check({tag, " latency"}, 64'(cyc - t0), 64'(exp_lat));
        check({tag, " rsp_id"},  64'(bus.rsp_id), 64'(oh2idx(exp_ready)));
        check({tag, " rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
        check({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
        check({tag, " mul_a/b"}, {32'd0, bus.mul_a, bus.mul_b}, {32'd0, a, b});
        check({tag, " starts"}, 64'(starts - s0), (exp_lat == 1) ? 64'd0 : 64'd1);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [15:0]  a;
        logic [15:0]  b;
        logic [N-1:0] exp_ready;
        logic [15:0]  exp_data;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int t0, s0, ptr_m, acc_idx, ntx, exp_id, exp_lat_r, w;
        logic first, pend, exp_err_r;
        logic [15:0] exp_data_r;
        logic [15:0] ra[N];
        logic [15:0] rb[N];
        logic [N-1:0] rv, eg;

        // Engine latency 3: normal responses appear 5 cycles after accept
        vecs[0]  = '{4'b0010, 16'h3C00, 16'h4000, 4'b0010, 16'h4000, 1'b0, 5};
        vecs[1]  = '{4'b1111, 16'h8000, 16'h4500, 4'b0100, 16'h8000, 1'b0, 1};
        vecs[2]  = '{4'b0011, 16'h4000, 16'h4000, 4'b0001, 16'h4400, 1'b0, 5};
        vecs[3]  = '{4'b1001, 16'h3C00, 16'h0000, 4'b1000, 16'h0000, 1'b0, 1};
        vecs[4]  = '{4'b1110, 16'hC000, 16'h3C00, 4'b0010, 16'hC000, 1'b0, 5};
        vecs[5]  = '{4'b0001, 16'h0001, 16'h4000, 4'b0001, 16'h0401, 1'b0, 5};
        vecs[6]  = '{4'b1111, 16'h8000, 16'h8000, 4'b0010, 16'h0000, 1'b0, 1};
        vecs[7]  = '{4'b1000, 16'h3C00, 16'h3C00, 4'b1000, 16'h3C00, 1'b0, 5};
        for (int i = 0; i < 8; i++) begin
            vecs[8 + i] = '{4'b1111, 16'h3C00, 16'h4000, 4'(1 << (i % 4)), 16'h4000, 1'b0, 5};
        end

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Power-on reset
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs",
              {6'd0, bus.req_ready, bus.rsp_valid, bus.mul_start, bus.busy,
               bus.mul_a, bus.mul_b, bus.rsp_data, bus.rsp_id, bus.rsp_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle busy", 64'(bus.busy), 64'd0);

        // Directed vector table (includes the 0,1,2,3,0,1,2,3 round-robin run)
        eng_lat = 3;
        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].exp_ready,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Timeout: engine silent, then stray done pulses in RESP and IDLE
        eng_lat = 0;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_a     = {N{16'h3C00}};
        bus.req_b     = {N{16'h4000}};
        bus.rsp_ready = 1'b0;
        #1;
        check("to grant", 64'(bus.req_ready), 64'b0001);
        t0 = cyc;
        s0 = starts;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        wait_rsp(TIMEOUT + 10);
        check("to latency", 64'(cyc - t0), 64'(TIMEOUT + 2));
        check("to data", 64'(bus.rsp_data), 64'h7E00);
        check("to err", 64'(bus.rsp_err), 64'd1);
        check("to starts", 64'(starts - s0), 64'd1);
        inj_req++;
        repeat (3) @(negedge clk);
        #1;
        check("to late done in resp",
              {46'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {46'd0, 1'b1, 1'b1, 16'h7E00});
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("to back to idle", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);
        inj_req++;
        repeat (3) @(negedge clk);
        #1;
        check("idle done ignored", {62'd0, bus.busy, bus.rsp_valid}, 64'd0);

        // Backpressure: response held for 5 cycles while all requesters wait
        eng_lat = 2;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_a     = {N{16'h4000}};
        bus.req_b     = {N{16'h3C00}};
        bus.rsp_ready = 1'b0;
        #1;
        check("bp grant", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        wait_rsp(TIMEOUT + 10);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold %0d", i),
                  {41'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready},
                  {41'd0, 1'b1, 2'd1, 16'h4000, 4'b0000});
            @(negedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp handshake no grant", 64'(bus.req_ready), 64'd0);
        @(negedge clk); #1;
        check("bp next grant", 64'(bus.req_ready), 64'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        wait_rsp(TIMEOUT + 10);
        check("bp next rsp", {46'd0, bus.rsp_id, bus.rsp_data}, {46'd0, 2'd2, 16'h4000});

        // Reset while the engine is busy
        eng_lat = 10;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        check("rst grant", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst in wait busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst mid-wait outputs",
              {6'd0, bus.req_ready, bus.rsp_valid, bus.mul_start, bus.busy,
               bus.mul_a, bus.mul_b, bus.rsp_data, bus.rsp_id, bus.rsp_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        eng_lat = 2;
        run_txn(4'b1111, 16'h3C00, 16'h4000, 4'b0001, 16'h4000, 1'b0, 4, "post-rst");

        // Randomized traffic against the transaction-level model
        ptr_m   = 1;
        rv      = '0;
        acc_idx = -1;
        ntx     = 0;
        first   = 1'b0;
        pend    = 1'b0;
        t0      = 0;
        exp_id  = 0;
        exp_lat_r  = 0;
        exp_data_r = '0;
        exp_err_r  = 1'b0;
        for (int c = 0; c < 8000 && ntx < 150; c++) begin
            @(negedge clk);
            if (acc_idx >= 0) begin
                rv[acc_idx] = 1'b0;
                acc_idx = -1;
            end
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = rand_op();
                    rb[i] = rand_op();
                end
            end
            bus.req_valid = rv;
            for (int i = 0; i < N; i++) begin
                bus.req_a[16*i +: 16] = ra[i];
                bus.req_b[16*i +: 16] = rb[i];
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.req_ready != '0) begin
                w  = model_winner(rv, ptr_m);
                eg = '0;
                if (w >= 0) eg[w] = 1'b1;
                check("rand grant", 64'(bus.req_ready), 64'(eg));
                if (w < 0) w = 0;
                eng_lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
                exp_id  = w;
                if (ra[w][14:0] == 15'd0 || rb[w][14:0] == 15'd0) begin
                    exp_data_r = {ra[w][15] ^ rb[w][15], 15'd0};
                    exp_err_r  = 1'b0;
                    exp_lat_r  = 1;
                end else if (eng_lat == 0) begin
                    exp_data_r = 16'h7E00;
                    exp_err_r  = 1'b1;
                    exp_lat_r  = TIMEOUT + 2;
                end else begin
                    exp_data_r = eng_f(ra[w], rb[w]);
                    exp_err_r  = 1'b0;
                    exp_lat_r  = eng_lat + 2;
                end
                acc_idx = w;
                t0      = cyc;
                first   = 1'b1;
                pend    = 1'b1;
            end
            if (bus.rsp_valid && pend) begin
                if (first) check("rand latency", 64'(cyc - t0), 64'(exp_lat_r));
                first = 1'b0;
                if (bus.rsp_ready) begin
                    check("rand rsp",
                          {45'd0, bus.rsp_id, bus.rsp_err, bus.rsp_data},
                          {45'd0, 2'(exp_id), exp_err_r, exp_data_r});
                    ptr_m = (exp_id + 1) % N;
                    pend  = 1'b0;
                    ntx++;
                end
            end
        end
        check("rand progress", 64'(ntx), 64'd150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/lmul_arbiter.md
Name: lmul_arbiter

Overview:
- Shares one multi-cycle FP16 logarithmic multiplier engine between N requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Sequences the engine through a start/done handshake and guards it with a timeout watchdog.
- Short-circuits zero operands without engaging the engine.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= N.
- TIMEOUT, 16, maximum WAIT cycles before abort (>= 2).
- BYPASS_ZERO, 1, enables the zero-operand bypass.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  N  per-requester request valid.
- req_a  in  16*N  FP16 operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*N  FP16 operand B; same packing as req_a.
- req_ready  out  N  one-hot accept; at most one bit high.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the requester the response belongs to.
- rsp_data  out  16  FP16 product.
- rsp_err  out  1  response produced by timeout.
- rsp_ready  in  1  response consumer ready.
- mul_start  out  1  single-cycle engine start pulse.
- mul_a  out  16  engine operand A.
- mul_b  out  16  engine operand B.
- mul_done  in  1  engine result-valid pulse.
- mul_result  in  16  engine product, valid when mul_done=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation):
  - State goes to IDLE; rr_ptr=0; timer=0.
  - mul_a, mul_b, rsp_data, rsp_id, rsp_err are cleared to 0.
  - rsp_valid, mul_start, req_ready, busy are 0.
  - An in-flight operation is dropped; a later mul_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g = first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo N.
  - req_ready[g]=1 is combinational from req_valid and rr_ptr, and is asserted only in IDLE.
  - The handshake completes in that same cycle: latch operands into mul_a/mul_b and latch id=g.
  - Zero bypass: if BYPASS_ZERO=1 and (a[14:0]==0 or b[14:0]==0), set rsp_data={a[15]^b[15],15'b0} and rsp_err=0, then go to RESP.
  - Otherwise go to ISSUE.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - mul_start=1 for exactly this cycle; timer=0; next state WAIT.
- WAIT:
  - mul_a and mul_b stay stable from the IDLE latch until the return to IDLE.
  - mul_done=1 (checked first): rsp_data<=mul_result, rsp_err<=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_data<=16'h7E00, rsp_err<=1, go to RESP.
  - Else timer<=timer+1.
  - If mul_done arrives in the same cycle the timeout would fire, the result wins and there is no error.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_err are held stable until rsp_ready=1.
  - On handshake: rr_ptr<=(id+1) mod N, go to IDLE. No new request is accepted in the handshake cycle.
- mul_done outside WAIT is ignored, with no state change.
- Latency:
  - Accept at cycle T; mul_start at T+1.
  - mul_done sampled at cycle D gives rsp_valid at D+1.
  - Bypass path: rsp_valid at T+1.
  - Timeout path: rsp_valid at T+2+TIMEOUT.
- Fairness: a continuously requesting requester is served at least once every N transactions.
- Exactly one transaction is outstanding at a time.
- Requesters must hold req_valid and operands stable until req_ready.

Test Plan:
- Single request: req_valid=4'b0010, a=16'h3C00, b=16'h4000; engine returns 16'h4000 after 3 cycles. Required: req_ready=4'b0010 in the accept cycle, one mul_start pulse, rsp_valid with rsp_id=1, rsp_data=16'h4000, rsp_err=0, one cycle after mul_done.
- Round-robin: req_valid=4'b1111 held for 8 transactions, rsp_ready=1. Required: grant order 0,1,2,3,0,1,2,3.
- Zero bypass: a=16'h8000, b=16'h4500. Required: mul_start never asserts; rsp_data=16'h8000, rsp_err=0, rsp_valid one cycle after accept.
- Timeout: engine never asserts mul_done, TIMEOUT=16. Required: rsp_valid with rsp_data=16'h7E00 and rsp_err=1 at T+18; a late mul_done afterwards has no effect.
- Backpressure: rsp_ready=0 for 5 cycles during RESP. Required: rsp_valid, rsp_id, rsp_data stable throughout; req_ready=0 throughout; the next grant follows the handshake.
- Reset mid-WAIT: drop rst_n during WAIT. Required: all outputs 0 immediately; the next request from requester 0 is accepted normally, with rr_ptr back at 0.
